freq_gate_sequencer: RTL and testbench

- Measurement controller for the frequency meter; sits between the divider bank and the pulse counter/display latch.
- Builds each gate window from the 1 kHz timebase tick and sequences the counter through clear, count, latch and hold.
- In auto mode, selects the gate range: steps to a shorter gate on overflow and to a longer gate on under-range.

---
 rtl/freq_gate_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_freq_gate_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_sequencer.sv
// freq_gate_sequencer: measurement controller for the frequency meter.
// Builds gate windows from the 1 kHz timebase, walks the pulse counter
// through clear / count / latch / hold, and in auto mode picks the gate
// range from the overflow and under-range status of each result.
module freq_gate_sequencer #(
  parameter int COUNT_W    = 24,
  parameter int UNDER_TH   = 1000,
  parameter int G0         = 1000,
  parameter int G1         = 100,
  parameter int G2         = 10,
  parameter int G3         = 1,
  parameter int HOLD_TICKS = 500,
  parameter int MAX_RETRY  = 3
) (
  input  logic               CLK_50,
  input  logic               RST,
  input  logic               tick_1k,
  input  logic               run,
  input  logic               auto,
  input  logic [1:0]         range_in,
  input  logic               cnt_ovf,
  input  logic [COUNT_W-1:0] cnt_value,
  output logic               cnt_clr,
  output logic               cnt_en,
  output logic               cnt_latch,
  output logic [1:0]         range,
  output logic               done,
  output logic               over_range,
  output logic               busy
);

  // One tick counter serves both the gate window and the display hold,
  // so it is sized for the longest of them.
  localparam int GMAX01   = (G0 > G1) ? G0 : G1;
  localparam int GMAX23   = (G2 > G3) ? G2 : G3;
  localparam int GMAX     = (GMAX01 > GMAX23) ? GMAX01 : GMAX23;
  localparam int TICK_MAX = (GMAX > HOLD_TICKS) ? GMAX : HOLD_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam int RETRY_W  = $clog2(MAX_RETRY + 1);

  localparam logic [COUNT_W-1:0] UNDER_L     = COUNT_W'(UNDER_TH);
  localparam logic [RETRY_W-1:0] MAX_RETRY_L = RETRY_W'(MAX_RETRY);
  localparam logic [TICK_W-1:0]  HOLD_LAST   = TICK_W'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    GATE,
    LATCH,
    EVAL,
    HOLD
  } state_t;

  state_t              state_q;
  logic                tickDelay_q;
  logic [TICK_W-1:0]   tickCnt_q;
  logic [RETRY_W-1:0]  retryCnt_q;
  logic                ovfSticky_q;
  logic                ovfS_q;
  logic                underS_q;
  logic                tickPulse;

  // Terminal count value for the gate length of a given range.
  function automatic logic [TICK_W-1:0] gateLast(input logic [1:0] r);
    logic [TICK_W-1:0] v;
    case (r)
      2'd0:    v = TICK_W'(G0 - 1);
      2'd1:    v = TICK_W'(G1 - 1);
      2'd2:    v = TICK_W'(G2 - 1);
      default: v = TICK_W'(G3 - 1);
    endcase
    return v;
  endfunction

  // Rising edge of the timebase; one clock wide.
  assign tickPulse = tick_1k & ~tickDelay_q;

  // Sequencer: state, counters and all outputs registered from the next state.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_q     <= IDLE;
      tickDelay_q <= 1'b0;
      tickCnt_q   <= '0;
      retryCnt_q  <= '0;
      ovfSticky_q <= 1'b0;
      ovfS_q      <= 1'b0;
      underS_q    <= 1'b0;
      cnt_clr     <= 1'b0;
      cnt_en      <= 1'b0;
      cnt_latch   <= 1'b0;
      range       <= 2'd0;
      done        <= 1'b0;
      over_range  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tickDelay_q <= tick_1k;
      cnt_clr     <= 1'b0;
      cnt_latch   <= 1'b0;
      done        <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!auto) range <= range_in;
          if (run) begin
            state_q    <= CLEAR;
            retryCnt_q <= '0;
            cnt_clr    <= 1'b1;
            busy       <= 1'b1;
          end
        end

        CLEAR: begin
          ovfSticky_q <= 1'b0;
          if (!auto) range <= range_in;
          state_q <= ARM;
        end

        ARM: begin
          if (tickPulse) begin
            tickCnt_q <= gateLast(range);
            state_q   <= GATE;
            cnt_en    <= 1'b1;
          end
        end

        GATE: begin
          if (cnt_ovf) ovfSticky_q <= 1'b1;
          if (tickPulse) begin
            if (tickCnt_q == '0) begin
              state_q   <= LATCH;
              cnt_en    <= 1'b0;
              cnt_latch <= 1'b1;
            end else begin
              tickCnt_q <= tickCnt_q - TICK_W'(1);
            end
          end
        end

        LATCH: begin
          ovfS_q   <= ovfSticky_q | cnt_ovf;
          underS_q <= (cnt_value < UNDER_L);
          state_q  <= EVAL;
        end

        EVAL: begin
          if (auto && ovfS_q && (range != 2'd3) && (retryCnt_q < MAX_RETRY_L)) begin
            range      <= range + 2'd1;
            retryCnt_q <= retryCnt_q + RETRY_W'(1);
            state_q    <= CLEAR;
            cnt_clr    <= 1'b1;
          end else if (auto && !ovfS_q && underS_q && (range != 2'd0) &&
                       (retryCnt_q < MAX_RETRY_L)) begin
            range      <= range - 2'd1;
            retryCnt_q <= retryCnt_q + RETRY_W'(1);
            state_q    <= CLEAR;
            cnt_clr    <= 1'b1;
          end else begin
            done       <= 1'b1;
            over_range <= ovfS_q;
            retryCnt_q <= '0;
            tickCnt_q  <= HOLD_LAST;
            state_q    <= HOLD;
          end
        end

        HOLD: begin
          if (tickPulse) begin
            if (tickCnt_q == '0) begin
              if (run) begin
                state_q <= CLEAR;
                cnt_clr <= 1'b1;
              end else begin
                state_q <= IDLE;
                busy    <= 1'b0;
              end
            end else begin
              tickCnt_q <= tickCnt_q - TICK_W'(1);
            end
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// tb_freq_gate_sequencer: directed scenarios for the gate sequencer.
// The timebase is sped up to one tick every 4 clocks so full-length gates
// (1000 ticks at range 0) and the 500-tick hold stay short in simulation.
`timescale 1ns/1ps
module tb_freq_gate_sequencer;

  localparam int SEL_EN   = 0;
  localparam int SEL_IDLE = 1;

  logic        CLK_50;
  logic        RST;
  logic        tick_1k;
  logic        run;
  logic        auto;
  logic [1:0]  range_in;
  logic        cnt_ovf;
  logic [23:0] cnt_value;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_latch;
  logic [1:0]  range;
  logic        done;
  logic        over_range;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  bit          ovfPlan   [8];
  logic [23:0] valuePlan [8];
  int          planBase  = 0;
  int          clrTotal  = 0;
  int          enRun     = 0;

  freq_gate_sequencer dut (
    .CLK_50     (CLK_50),
    .RST        (RST),
    .tick_1k    (tick_1k),
    .run        (run),
    .auto       (auto),
    .range_in   (range_in),
    .cnt_ovf    (cnt_ovf),
    .cnt_value  (cnt_value),
    .cnt_clr    (cnt_clr),
    .cnt_en     (cnt_en),
    .cnt_latch  (cnt_latch),
    .range      (range),
    .done       (done),
    .over_range (over_range),
    .busy       (busy)
  );

  // 50 MHz system clock.
  initial begin
    CLK_50 = 1'b0;
    forever #10 CLK_50 = ~CLK_50;
  end

  // Accelerated timebase: square wave with a 4-clock period.
  initial begin
    tick_1k = 1'b0;
    forever begin
      repeat (2) @(negedge CLK_50);
      tick_1k = ~tick_1k;
    end
  end

  // Counter model: per-measurement overflow pulse and live value from the plan.
  initial begin
    int idx;
    cnt_ovf   = 1'b0;
    cnt_value = 24'd5000;
    forever begin
      @(negedge CLK_50);
      if (cnt_clr) clrTotal++;
      if (cnt_en) enRun++;
      else enRun = 0;
      idx = clrTotal - planBase - 1;
      if (idx >= 0 && idx < 8) begin
        cnt_ovf   = cnt_en && ovfPlan[idx] && (enRun == 2);
        cnt_value = valuePlan[idx];
      end else begin
        cnt_ovf   = 1'b0;
        cnt_value = 24'd5000;
      end
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #1800000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic pick(input int sel);
    if (sel == SEL_EN) return cnt_en;
    return !busy;
  endfunction

  task automatic waitHigh(input int sel, input int limit, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK_50);
      if (pick(sel)) begin
        ok = 1'b1;
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic clearPlan();
    for (int i = 0; i < 8; i++) begin
      ovfPlan[i]   = 1'b0;
      valuePlan[i] = 24'd5000;
    end
    planBase = clrTotal;
  endtask

  task automatic setIdleRange(input logic [1:0] r);
    run      = 1'b0;
    auto     = 1'b0;
    range_in = r;
    repeat (2) @(negedge CLK_50);
  endtask

  // Watches one measurement until done, collecting pulse counts and timing.
  task automatic monitorUntilDone(input int limit, input logic [1:0] expRange,
                                  output int clrs, output int latches, output int enCyc,
                                  output int gap, output int rangeBad, output bit seen);
    int latchAt;
    clrs = 0; latches = 0; enCyc = 0; gap = -1; rangeBad = 0; seen = 1'b0;
    latchAt = -100;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(negedge CLK_50);
      if (cnt_clr) clrs++;
      if (cnt_en) enCyc++;
      if (range !== expRange) rangeBad++;
      if (cnt_latch) begin
        latches++;
        latchAt = cyc;
      end
      if (done) begin
        seen = 1'b1;
        gap = cyc - latchAt;
        break;
      end
    end
  endtask

  // Reset values, then reset asserted in the middle of a gate.
  task automatic test_reset();
    int cyc;
    bit ok;
    RST = 1'b1; run = 1'b0; auto = 1'b0; range_in = 2'd0;
    repeat (3) @(negedge CLK_50);
    vectors++;
    if ({cnt_clr, cnt_en, cnt_latch, done, over_range, busy} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b, expected 000000",
               {cnt_clr, cnt_en, cnt_latch, done, over_range, busy});
    end
    vectors++;
    if (range !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_range: got %0d, expected 0", range);
    end
    RST = 1'b0; range_in = 2'd1; run = 1'b1;
    waitHigh(SEL_EN, 20, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL reset_gate_start: got cnt_en=0 after 20 cycles, expected 1");
    end
    vectors++;
    if (range !== 2'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gate_range_busy: got range=%0d busy=%b, expected range=1 busy=1", range, busy);
    end
    repeat (3) @(negedge CLK_50);
    RST = 1'b1;
    @(negedge CLK_50);
    vectors++;
    if (cnt_en !== 1'b0 || range !== 2'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_gate: got cnt_en=%b range=%0d busy=%b, expected 0 0 0",
               cnt_en, range, busy);
    end
    vectors++;
    if ({cnt_clr, cnt_latch, done, over_range} !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_gate_pulses: got %b, expected 0000",
               {cnt_clr, cnt_latch, done, over_range});
    end
    RST = 1'b0; run = 1'b0; range_in = 2'd0;
    repeat (3) @(negedge CLK_50);
    vectors++;
    if (busy !== 1'b0 || cnt_clr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got busy=%b cnt_clr=%b, expected 0 0", busy, cnt_clr);
    end
  endtask

  // Manual range 2: one clean 10-tick gate, latch, done two cycles later.
  task automatic test_manual_range();
    int clrs, latches, enCyc, gap, rangeBad, cyc;
    bit seen, ok;
    setIdleRange(2'd2);
    clearPlan();
    run = 1'b1;
    monitorUntilDone(3000, 2'd2, clrs, latches, enCyc, gap, rangeBad, seen);
    run = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL manual_done: got no done in 3000 cycles, expected done");
    end
    vectors++;
    if (clrs != 1 || latches != 1) begin
      miscompares++;
      $display("[TB] FAIL manual_pulses: got clr=%0d latch=%0d, expected 1 1", clrs, latches);
    end
    vectors++;
    if (enCyc < 39 || enCyc > 41) begin
      miscompares++;
      $display("[TB] FAIL manual_gate_len: got %0d cycles, expected 40 +-1", enCyc);
    end
    vectors++;
    if (gap != 2) begin
      miscompares++;
      $display("[TB] FAIL manual_latch_to_done: got %0d, expected 2", gap);
    end
    vectors++;
    if (rangeBad != 0 || over_range !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL manual_range_ovr: got rangeBad=%0d over_range=%b, expected 0 0",
               rangeBad, over_range);
    end
    waitHigh(SEL_IDLE, 2200, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL manual_to_idle: got busy=1 after 2200 cycles, expected 0");
    end
  endtask

  // Auto from range 0: overflow at ranges 0 and 1, clean at range 2.
  task automatic test_auto_ovf_step();
    int clrs, latches, enCyc, gap, rangeBad, cyc;
    bit seen, ok;
    setIdleRange(2'd0);
    clearPlan();
    ovfPlan[0] = 1'b1;
    ovfPlan[1] = 1'b1;
    auto = 1'b1; run = 1'b1;
    monitorUntilDone(6000, 2'd2, clrs, latches, enCyc, gap, rangeBad, seen);
    run = 1'b0;
    vectors++;
    if (!seen || clrs != 3 || latches != 3) begin
      miscompares++;
      $display("[TB] FAIL auto_step_count: got done=%b clr=%0d latch=%0d, expected 1 3 3",
               seen, clrs, latches);
    end
    vectors++;
    if (range !== 2'd2 || over_range !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL auto_step_result: got range=%0d over_range=%b, expected 2 0",
               range, over_range);
    end
    waitHigh(SEL_IDLE, 2200, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL auto_step_idle: got busy=1 after 2200 cycles, expected 0");
    end
  endtask

  // Auto with overflow every gate: saturates at range 3 and flags over_range.
  task automatic test_auto_saturate();
    int clrs, latches, enCyc, gap, rangeBad, cyc;
    bit seen, ok;
    setIdleRange(2'd0);
    clearPlan();
    for (int i = 0; i < 8; i++) ovfPlan[i] = 1'b1;
    auto = 1'b1; run = 1'b1;
    monitorUntilDone(6000, 2'd3, clrs, latches, enCyc, gap, rangeBad, seen);
    run = 1'b0;
    vectors++;
    if (!seen || clrs != 4) begin
      miscompares++;
      $display("[TB] FAIL saturate_count: got done=%b clr=%0d, expected 1 4", seen, clrs);
    end
    vectors++;
    if (range !== 2'd3 || over_range !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL saturate_result: got range=%0d over_range=%b, expected 3 1",
               range, over_range);
    end
    waitHigh(SEL_IDLE, 2200, cyc, ok);
    vectors++;
    if (!ok || over_range !== 1'b1 || range !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL saturate_hold_flag: got idle=%b over_range=%b range=%0d, expected 1 1 3",
               ok, over_range, range);
    end
  endtask

  // Auto from range 2 with a tiny count: steps down to range 0 and accepts.
  task automatic test_under_range();
    int clrs, latches, enCyc, gap, rangeBad, cyc;
    bit seen, ok;
    setIdleRange(2'd2);
    vectors++;
    if (range !== 2'd2 || over_range !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL under_setup: got range=%0d over_range=%b, expected 2 1", range, over_range);
    end
    clearPlan();
    for (int i = 0; i < 8; i++) valuePlan[i] = 24'd5;
    auto = 1'b1; run = 1'b1;
    monitorUntilDone(6000, 2'd0, clrs, latches, enCyc, gap, rangeBad, seen);
    run = 1'b0;
    vectors++;
    if (!seen || clrs != 3) begin
      miscompares++;
      $display("[TB] FAIL under_count: got done=%b clr=%0d, expected 1 3", seen, clrs);
    end
    vectors++;
    if (range !== 2'd0 || over_range !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL under_result: got range=%0d over_range=%b, expected 0 0", range, over_range);
    end
    waitHigh(SEL_IDLE, 2200, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL under_idle: got busy=1 after 2200 cycles, expected 0");
    end
  endtask

  // Alternating overflow / under-range: retry limit ends it; run dropped in HOLD.
  task automatic test_oscillation();
    int clrs, latches, enCyc, gap, rangeBad, holdCyc, extraClr;
    bit seen, ok;
    setIdleRange(2'd0);
    clearPlan();
    ovfPlan[0]   = 1'b1;
    valuePlan[1] = 24'd5;
    ovfPlan[2]   = 1'b1;
    valuePlan[3] = 24'd5;
    valuePlan[4] = 24'd5;
    auto = 1'b1; run = 1'b1;
    monitorUntilDone(10000, 2'd1, clrs, latches, enCyc, gap, rangeBad, seen);
    run = 1'b0;
    vectors++;
    if (!seen || clrs != 4) begin
      miscompares++;
      $display("[TB] FAIL osc_retries: got done=%b measurements=%0d, expected 1 4", seen, clrs);
    end
    vectors++;
    if (range !== 2'd1 || over_range !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL osc_result: got range=%0d over_range=%b, expected 1 0", range, over_range);
    end
    ok = 1'b0; holdCyc = 0; extraClr = 0;
    for (int i = 0; i < 2200; i++) begin
      @(negedge CLK_50);
      if (cnt_clr) extraClr++;
      if (!busy) begin
        ok = 1'b1;
        holdCyc = i + 1;
        break;
      end
    end
    vectors++;
    if (!ok || holdCyc < 1990 || holdCyc > 2010) begin
      miscompares++;
      $display("[TB] FAIL osc_hold_len: got idle=%b after %0d cycles, expected 1 after ~2000",
               ok, holdCyc);
    end
    vectors++;
    if (extraClr != 0) begin
      miscompares++;
      $display("[TB] FAIL osc_no_restart: got %0d clears, expected 0", extraClr);
    end
  endtask

  // Manual range 3 with run held: second measurement follows the hold,
  // and an overflow at the manual range sets over_range without a retry.
  task automatic test_back_to_back();
    int clrs, latches, enCyc, gap, rangeBad, cyc;
    bit seen, ok;
    setIdleRange(2'd3);
    clearPlan();
    ovfPlan[1] = 1'b1;
    run = 1'b1;
    monitorUntilDone(100, 2'd3, clrs, latches, enCyc, gap, rangeBad, seen);
    vectors++;
    if (!seen || clrs != 1 || enCyc < 3 || enCyc > 5) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got done=%b clr=%0d gate=%0d, expected 1 1 4",
               seen, clrs, enCyc);
    end
    vectors++;
    if (over_range !== 1'b0 || rangeBad != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_flags: got over_range=%b rangeBad=%0d, expected 0 0",
               over_range, rangeBad);
    end
    monitorUntilDone(2300, 2'd3, clrs, latches, enCyc, gap, rangeBad, seen);
    run = 1'b0;
    vectors++;
    if (!seen || clrs != 1 || latches != 1 || gap != 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got done=%b clr=%0d latch=%0d gap=%0d, expected 1 1 1 2",
               seen, clrs, latches, gap);
    end
    vectors++;
    if (over_range !== 1'b1 || range !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL b2b_manual_ovf: got over_range=%b range=%0d, expected 1 3",
               over_range, range);
    end
    waitHigh(SEL_IDLE, 2200, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle: got busy=1 after 2200 cycles, expected 0");
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    RST = 1'b1; run = 1'b0; auto = 1'b0; range_in = 2'd0;
    for (int i = 0; i < 8; i++) begin
      ovfPlan[i]   = 1'b0;
      valuePlan[i] = 24'd5000;
    end
    test_reset();
    test_manual_range();
    test_auto_ovf_step();
    test_auto_saturate();
    test_under_range();
    test_oscillation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
